tag_alloc_ctrl: RTL and testbench

TAG_ALLOC_CTRL -- requirements
Module: tag_alloc_ctrl

---
 rtl/tag_alloc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_tag_alloc_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_alloc_ctrl.sv
// tag_alloc_ctrl
//   Destination-tag allocation controller sitting in front of a physical-tag
//   free list. Up to two decode slots request tags each cycle. Allocation is
//   all-or-nothing and fully combinational. Tags released at commit are
//   buffered in a small circular release queue and pushed back into the free
//   list one per cycle.
//
//   Optional feature (macro TAG_ALLOC_STALL_CNT_EN): adds a 32-bit saturating
//   counter of allocation-stall cycles on output stall_count.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   alloc_req_0/1              decode slot 0/1 wants a destination tag
//   alloc_grant                every requested tag is supplied this cycle
//   alloc_tag_0/1              granted tags (valid while alloc_grant=1)
//   alloc_stall                a request is present but not granted
//   free_valid_0/1, free_tag_0/1  commit releases (slot 0 queued first)
//   free_ready                 release queue has room for two tags
//   flush                      pipeline flush, blocks allocation
//   fl_read_tag_dest_0/1       free-list head and head+1
//   fl_num_items               free-list occupancy
//   fl_read_1_tag/2_tags       pop one / two tags from the free list
//   fl_write_tag, fl_write_tag_source  push one tag into the free list
//   ctrl_state                 FSM state: 0 INIT, 1 RUN, 2 FLUSH
//   stall_count                (TAG_ALLOC_STALL_CNT_EN only) stall cycles
//
// Handshake: a release is accepted in a cycle where free_valid_x=1 and
// free_ready=1. free_ready depends only on registered occupancy, so a source
// may sample it before deciding to release. A release offered while
// free_ready=0 is discarded.
module tag_alloc_ctrl #(
  parameter int WIDTH       = 128,
  parameter int RQ_DEPTH    = 4,
  parameter int INIT_CYCLES = 2,
  localparam int TW         = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req_0,
  input  logic          alloc_req_1,
  output logic          alloc_grant,
  output logic [TW-1:0] alloc_tag_0,
  output logic [TW-1:0] alloc_tag_1,
  output logic          alloc_stall,
  input  logic          free_valid_0,
  input  logic          free_valid_1,
  input  logic [TW-1:0] free_tag_0,
  input  logic [TW-1:0] free_tag_1,
  output logic          free_ready,
  input  logic          flush,
  input  logic [TW-1:0] fl_read_tag_dest_0,
  input  logic [TW-1:0] fl_read_tag_dest_1,
  input  logic [TW-1:0] fl_num_items,
  output logic          fl_read_1_tag,
  output logic          fl_read_2_tags,
  output logic          fl_write_tag,
  output logic [TW-1:0] fl_write_tag_source,
  output logic [1:0]    ctrl_state
`ifdef TAG_ALLOC_STALL_CNT_EN
  ,
  output logic [31:0]   stall_count
`endif
);

  localparam int PW        = $clog2(RQ_DEPTH);
  localparam int CW        = PW + 1;
  localparam int IW        = $clog2(INIT_CYCLES + 1) + 1;
  localparam int INIT_LAST = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            init_done;

  logic [TW-1:0]   rq_mem [RQ_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, wr_ptr_inc;
  logic [CW-1:0]   count_q;
  logic            rq_empty;
  logic            deq;
  logic            enq_0, enq_1;
  logic [1:0]      n_enq;
  logic [1:0]      n_req;

  // ---------------------------------------------------------------- FSM
  assign init_done = (init_cnt_q == IW'(INIT_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // A flush seen during INIT is remembered so INIT always completes first and
  // then the controller enters FLUSH even if flush has since dropped.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      ST_INIT: begin
        if (init_done) begin
          state_d      = (flush || flush_pend_q) ? ST_FLUSH : ST_RUN;
          flush_pend_d = 1'b0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
          if (flush) flush_pend_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!flush && rq_empty) state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign ctrl_state = state_q;

  // --------------------------------------------------------- allocation
  assign n_req       = {1'b0, alloc_req_0} + {1'b0, alloc_req_1};
  assign alloc_grant = (state_q == ST_RUN) && (n_req != 2'd0) &&
                       (fl_num_items >= TW'(n_req)) && !flush;
  assign alloc_stall = (n_req != 2'd0) && !alloc_grant;

  // A single requester always takes the free-list head, whichever slot it is.
  always_comb begin
    alloc_tag_0    = '0;
    alloc_tag_1    = '0;
    fl_read_1_tag  = 1'b0;
    fl_read_2_tags = 1'b0;
    if (alloc_grant) begin
      if (n_req == 2'd2) begin
        alloc_tag_0    = fl_read_tag_dest_0;
        alloc_tag_1    = fl_read_tag_dest_1;
        fl_read_2_tags = 1'b1;
      end else begin
        fl_read_1_tag = 1'b1;
        if (alloc_req_0) alloc_tag_0 = fl_read_tag_dest_0;
        else             alloc_tag_1 = fl_read_tag_dest_0;
      end
    end
  end

  // ------------------------------------------------------ release queue
  assign rq_empty   = (count_q == '0);
  assign free_ready = (count_q <= CW'(RQ_DEPTH - 2));
  assign enq_0      = free_ready && free_valid_0;
  assign enq_1      = free_ready && free_valid_1;
  assign n_enq      = {1'b0, enq_0} + {1'b0, enq_1};
  assign wr_ptr_inc = wr_ptr_q + PW'(1);

  // Draining is held off only in INIT; the head leaves the queue in the same
  // cycle it is presented to the free list.
  assign deq                 = !rq_empty && (state_q != ST_INIT);
  assign fl_write_tag        = deq;
  assign fl_write_tag_source = rq_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (enq_0) rq_mem[wr_ptr_q] <= free_tag_0;
    if (enq_1) rq_mem[enq_0 ? wr_ptr_inc : wr_ptr_q] <= free_tag_1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(n_enq);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_q + CW'(n_enq) - CW'(deq);
    end
  end

  release_drop_chk: assert property (@(posedge clk) disable iff (reset)
    !((free_valid_0 || free_valid_1) && !free_ready))
    else $warning("tag_alloc_ctrl: release offered while free_ready=0, dropped");

  // ------------------------------------------------ optional stall counter
`ifdef TAG_ALLOC_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (alloc_stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Testbench for tag_alloc_ctrl: vector table for allocation decode, directed
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_tag_alloc_ctrl;

  localparam int WIDTH       = 128;
  localparam int RQ_DEPTH    = 4;
  localparam int INIT_CYCLES = 2;
  localparam int TW          = 8;

  // ------------------------------------------------ clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alloc_req_0 = 1'b0, alloc_req_1 = 1'b0;
  logic          alloc_grant, alloc_stall;
  logic [TW-1:0] alloc_tag_0, alloc_tag_1;
  logic          free_valid_0 = 1'b0, free_valid_1 = 1'b0;
  logic [TW-1:0] free_tag_0 = '0, free_tag_1 = '0;
  logic          free_ready;
  logic          flush = 1'b0;
  logic [TW-1:0] fl_read_tag_dest_0 = '0, fl_read_tag_dest_1 = '0;
  logic [TW-1:0] fl_num_items = '0;
  logic          fl_read_1_tag, fl_read_2_tags, fl_write_tag;
  logic [TW-1:0] fl_write_tag_source;
  logic [1:0]    ctrl_state;
`ifdef TAG_ALLOC_STALL_CNT_EN
  logic [31:0]   stall_count;
`endif

  always #5 clk = ~clk;

  tag_alloc_ctrl #(.WIDTH(WIDTH), .RQ_DEPTH(RQ_DEPTH), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
    .alloc_grant(alloc_grant), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
    .alloc_stall(alloc_stall),
    .free_valid_0(free_valid_0), .free_valid_1(free_valid_1),
    .free_tag_0(free_tag_0), .free_tag_1(free_tag_1), .free_ready(free_ready),
    .flush(flush),
    .fl_read_tag_dest_0(fl_read_tag_dest_0), .fl_read_tag_dest_1(fl_read_tag_dest_1),
    .fl_num_items(fl_num_items),
    .fl_read_1_tag(fl_read_1_tag), .fl_read_2_tags(fl_read_2_tags),
    .fl_write_tag(fl_write_tag), .fl_write_tag_source(fl_write_tag_source),
    .ctrl_state(ctrl_state)
`ifdef TAG_ALLOC_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 INIT / 1 RUN / 2 FLUSH, release queue as a queue.
  logic [TW-1:0] exp_q[$];
  int            m_mode;
  int            m_cyc;
  bit            m_flush_seen;
  logic          e_write, e_ready;

  task automatic model_reset();
    exp_q.delete();
    m_mode       = 0;
    m_cyc        = 0;
    m_flush_seen = 1'b0;
  endtask

  function automatic logic m_ready();
    return (RQ_DEPTH - exp_q.size()) >= 2;
  endfunction

  function automatic logic [31:0] pack(input logic g, input logic st,
      input logic [7:0] t0, input logic [7:0] t1, input logic r1, input logic r2,
      input logic w, input logic [7:0] src, input logic rdy, input logic [1:0] s);
    return {g, st, t0, t1, r1, r2, w, src, rdy, s};
  endfunction

  // Settle, then compare every output against the model.
  task automatic sample(input string name);
    int            n;
    logic          g, st, r1, r2;
    logic [TW-1:0] t0, t1, src;
    #1;
    n  = int'(alloc_req_0) + int'(alloc_req_1);
    g  = (m_mode == 1) && (n > 0) && (int'(fl_num_items) >= n) && !flush;
    st = (n > 0) && !g;
    t0 = '0; t1 = '0; r1 = 1'b0; r2 = 1'b0;
    if (g && n == 2) begin
      t0 = fl_read_tag_dest_0; t1 = fl_read_tag_dest_1; r2 = 1'b1;
    end else if (g) begin
      r1 = 1'b1;
      if (alloc_req_0) t0 = fl_read_tag_dest_0;
      else             t1 = fl_read_tag_dest_0;
    end
    e_ready = m_ready();
    e_write = (exp_q.size() > 0) && (m_mode != 0);
    src     = e_write ? exp_q[0] : 8'h00;
    check(name,
      pack(alloc_grant, alloc_stall, alloc_tag_0, alloc_tag_1, fl_read_1_tag,
           fl_read_2_tags, fl_write_tag, e_write ? fl_write_tag_source : 8'h00,
           free_ready, ctrl_state),
      pack(g, st, t0, t1, r1, r2, e_write, src, e_ready, 2'(m_mode)));
  endtask

  // Apply one clock edge to the model and the DUT.
  task automatic advance();
    bit was_empty;
    was_empty = (exp_q.size() == 0);
    if (e_write) void'(exp_q.pop_front());
    if (e_ready) begin
      if (free_valid_0) exp_q.push_back(free_tag_0);
      if (free_valid_1) exp_q.push_back(free_tag_1);
    end
    case (m_mode)
      0: begin
        if (flush) m_flush_seen = 1'b1;
        m_cyc++;
        if (m_cyc >= INIT_CYCLES) m_mode = m_flush_seen ? 2 : 1;
      end
      1: if (flush) m_mode = 2;
      default: if (!flush && was_empty) m_mode = 1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name);
    sample(name);
    advance();
  endtask

  task automatic clear_ctrl();
    alloc_req_0 = 1'b0; alloc_req_1 = 1'b0; flush = 1'b0;
    free_valid_0 = 1'b0; free_valid_1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_ctrl();
    model_reset();
    sample("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ------------------------------------------------------ vector table
  typedef struct {
    logic r0; logic r1; logic [7:0] items; logic [7:0] d0; logic [7:0] d1;
    logic g;  logic st; logic [7:0] t0;    logic [7:0] t1; logic rd1; logic rd2;
  } vec_t;
  vec_t vecs [10];

  // ------------------------------------------------------------- test
  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'd5,   8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd1,   8'h05, 8'h06, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'd1,   8'h07, 8'h08, 1'b1, 1'b0, 8'h00, 8'h07, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'd2,   8'h09, 8'h0a, 1'b1, 1'b0, 8'h09, 8'h0a, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'd1,   8'h0b, 8'h0c, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'd0,   8'h0d, 8'h0e, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'd0,   8'h0f, 8'h10, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'd0,   8'h11, 8'h12, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'd128, 8'h7f, 8'h80, 1'b1, 1'b0, 8'h7f, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 8'd0,   8'h13, 8'h14, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset values and INIT timing, then the first dual grant.
    fl_num_items = 8'd127; fl_read_tag_dest_0 = 8'h00; fl_read_tag_dest_1 = 8'h01;
    model_reset();
    #1;
    check("rst_grant", 32'(alloc_grant), 32'd0);
    check("rst_stall", 32'(alloc_stall), 32'd0);
    check("rst_ready", 32'(free_ready), 32'd1);
    check("rst_state", 32'(ctrl_state), 32'd0);
    check("rst_write", 32'(fl_write_tag), 32'd0);
    check("rst_reads", 32'({fl_read_1_tag, fl_read_2_tags}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sample("init0"); check("init0_state", 32'(ctrl_state), 32'd0); advance();
    sample("init1"); check("init1_state", 32'(ctrl_state), 32'd0); advance();
    alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
    sample("first_grant");
    check("run_state", 32'(ctrl_state), 32'd1);
    check("first_grant", 32'({alloc_grant, alloc_tag_0, alloc_tag_1, fl_read_2_tags}),
          32'({1'b1, 8'h00, 8'h01, 1'b1}));
    advance();

    // Allocation decode table.
    for (int i = 0; i < 10; i++) begin
      alloc_req_0 = vecs[i].r0; alloc_req_1 = vecs[i].r1;
      fl_num_items = vecs[i].items;
      fl_read_tag_dest_0 = vecs[i].d0; fl_read_tag_dest_1 = vecs[i].d1;
      sample($sformatf("vec%0d_model", i));
      check($sformatf("vec%0d", i),
        32'({alloc_grant, alloc_stall, alloc_tag_0, alloc_tag_1, fl_read_1_tag, fl_read_2_tags}),
        32'({vecs[i].g, vecs[i].st, vecs[i].t0, vecs[i].t1, vecs[i].rd1, vecs[i].rd2}));
      advance();
    end
    clear_ctrl();

    // Dual release drains one per cycle in slot order.
    free_valid_0 = 1'b1; free_valid_1 = 1'b1; free_tag_0 = 8'h10; free_tag_1 = 8'h11;
    sample("rel_c0"); check("rel_c0_write", 32'(fl_write_tag), 32'd0); advance();
    clear_ctrl();
    sample("rel_c1"); check("rel_c1", 32'({fl_write_tag, fl_write_tag_source}), 32'h110); advance();
    sample("rel_c2"); check("rel_c2", 32'({fl_write_tag, fl_write_tag_source}), 32'h111); advance();
    sample("rel_c3"); check("rel_c3_write", 32'(fl_write_tag), 32'd0); advance();

    // Not enough free tags: no partial grant; then a lone slot-1 request.
    fl_num_items = 8'd1; fl_read_tag_dest_0 = 8'h22; fl_read_tag_dest_1 = 8'h23;
    alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
    sample("short");
    check("short", 32'({alloc_grant, alloc_stall, fl_read_1_tag, fl_read_2_tags}), 32'b0100);
    advance();
    alloc_req_0 = 1'b0;
    sample("slot1_only");
    check("slot1_only", 32'({alloc_grant, alloc_tag_1, fl_read_1_tag}), 32'({1'b1, 8'h22, 1'b1}));
    advance();
    clear_ctrl();

    // Queue full: third pair dropped.
    free_valid_0 = 1'b1; free_valid_1 = 1'b1; free_tag_0 = 8'h21; free_tag_1 = 8'h22;
    step("full_c0");
    free_tag_0 = 8'h23; free_tag_1 = 8'h24;
    sample("full_c1"); check("full_c1_ready", 32'(free_ready), 32'd1); advance();
    free_tag_0 = 8'h25; free_tag_1 = 8'h26;
    sample("full_c2"); check("full_c2_ready", 32'(free_ready), 32'd0);
    check("full_c2_src", 32'(fl_write_tag_source), 32'h22); advance();
    clear_ctrl();
    sample("full_c3"); check("full_c3", 32'({fl_write_tag, fl_write_tag_source}), 32'h123); advance();
    sample("full_c4"); check("full_c4", 32'({fl_write_tag, fl_write_tag_source}), 32'h124); advance();
    sample("full_c5"); check("full_c5_write", 32'(fl_write_tag), 32'd0); advance();

    // Flush with two queued tags.
    fl_num_items = 8'd4;
    free_valid_0 = 1'b1; free_valid_1 = 1'b1; free_tag_0 = 8'h30; free_tag_1 = 8'h31;
    step("flush_p");
    clear_ctrl();
    flush = 1'b1; alloc_req_0 = 1'b1; alloc_req_1 = 1'b1;
    sample("flush_q");
    check("flush_q", 32'({ctrl_state, alloc_grant, fl_write_tag_source}), 32'({2'd1, 1'b0, 8'h30}));
    advance();
    flush = 1'b0;
    sample("flush_r");
    check("flush_r", 32'({ctrl_state, alloc_grant, fl_write_tag_source}), 32'({2'd2, 1'b0, 8'h31}));
    advance();
    sample("flush_s");
    check("flush_s", 32'({ctrl_state, alloc_grant, fl_write_tag}), 32'({2'd2, 1'b0, 1'b0}));
    advance();
    sample("flush_t");
    check("flush_t", 32'({ctrl_state, alloc_grant}), 32'({2'd1, 1'b1}));
    advance();
    clear_ctrl();

    // Flush during INIT is deferred until INIT ends.
    do_reset();
    flush = 1'b1;
    step("iflush_c0");
    flush = 1'b0;
    step("iflush_c1");
    sample("iflush_c2"); check("iflush_c2_state", 32'(ctrl_state), 32'd2); advance();
    sample("iflush_c3"); check("iflush_c3_state", 32'(ctrl_state), 32'd1); advance();

    // Reset mid-operation discards queued tags.
    free_valid_0 = 1'b1; free_valid_1 = 1'b1; free_tag_0 = 8'h40; free_tag_1 = 8'h41;
    step("mrst_c0");
    clear_ctrl();
    sample("mrst_c1"); check("mrst_c1_src", 32'(fl_write_tag_source), 32'h40); advance();
    reset = 1'b1;
    model_reset();
    #1;
    check("mrst_async", 32'({fl_write_tag, free_ready, ctrl_state}), 32'({1'b0, 1'b1, 2'd0}));
    @(posedge clk); #1;
    check("mrst_next", 32'(fl_write_tag), 32'd0);
    reset = 1'b0;
    step("mrst_i0");
    step("mrst_i1");
    sample("mrst_run"); check("mrst_discard", 32'(fl_write_tag), 32'd0); advance();

`ifdef TAG_ALLOC_STALL_CNT_EN
    fl_num_items = 8'd0;
    alloc_req_0 = 1'b1;
    repeat (5) step("stallcnt");
    alloc_req_0 = 1'b0;
    sample("stallcnt_end"); check("stall_count", stall_count, 32'd5);
    reset = 1'b1;
    model_reset();
    #1;
    check("stall_count_rst", stall_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        alloc_req_0 = 1'($urandom_range(0, 1));
        alloc_req_1 = 1'($urandom_range(0, 1));
        fl_num_items = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 3));
        fl_read_tag_dest_0 = 8'($urandom_range(0, 255));
        fl_read_tag_dest_1 = 8'($urandom_range(0, 255));
        if (flush) flush = ($urandom_range(0, 2) != 0);
        else       flush = ($urandom_range(0, 15) == 0);
        free_tag_0 = 8'($urandom_range(0, 255));
        free_tag_1 = 8'($urandom_range(0, 255));
        if (m_ready()) begin
          free_valid_0 = 1'($urandom_range(0, 1));
          free_valid_1 = 1'($urandom_range(0, 1));
        end else begin
          free_valid_0 = 1'b0;
          free_valid_1 = 1'b0;
        end
        step("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
